// File: rtl/dft_dump_host.sv
// Host-side initiator for the DFT scan-dump protocol: requests an operation,
// captures strobed scan-out words into a small buffer, then acknowledges the commit.
module dft_dump_host #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic [ADDR_W:0]   word_cnt,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              dft_val_op,
    input  logic              dft_op_ack,
    input  logic [31:0]       dft_out,
    input  logic              dft_out_strobe,
    input  logic              dft_op_commit,
    output logic              dft_commit_ack,
    output logic [2:0]        dbg_state
);

    // Handshakes: dft_val_op is held until dft_op_ack is sampled high; dft_commit_ack
    // is held from the cycle after dft_op_commit rises until it is sampled low.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAPTURE = 3'd2,
        S_ACK     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              err_overflow_q, err_overflow_d;
    logic              err_timeout_q, err_timeout_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              val_op_q, val_op_d;
    logic              commit_ack_q, commit_ack_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [31:0]       buf_q [DEPTH];
    logic              buf_we;
    logic              in_cap;
    logic              tmo_hit;

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        err_overflow_d = err_overflow_q;
        err_timeout_d  = err_timeout_q;
        tmo_cnt_d      = tmo_cnt_q;
        buf_we         = 1'b0;
        in_cap         = (state_q == S_REQ) || (state_q == S_CAPTURE);
        tmo_hit        = (TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_LAST);

        if (in_cap) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (dft_out_strobe) begin
                if (word_cnt_q < DEPTH_CNT) begin
                    buf_we     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                end else begin
                    err_overflow_d = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_REQ;
                    word_cnt_d     = '0;
                    err_overflow_d = 1'b0;
                    err_timeout_d  = 1'b0;
                    tmo_cnt_d      = '0;
                end
            end
            S_REQ: begin
                if (dft_op_ack) begin
                    state_d = S_CAPTURE;
                end else if (tmo_hit) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (dft_op_commit) begin
                    state_d = S_ACK;
                end else if (tmo_hit) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end
            end
            S_ACK: begin
                if (!dft_op_commit) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear right after the edge.
        busy_d       = (state_d == S_REQ) || (state_d == S_CAPTURE) || (state_d == S_ACK);
        done_d       = (state_d == S_DONE);
        val_op_d     = (state_d == S_REQ);
        commit_ack_d = (state_d == S_ACK);
        rd_data_d    = buf_q[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            word_cnt_q     <= '0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            tmo_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            val_op_q       <= 1'b0;
            commit_ack_q   <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
            tmo_cnt_q      <= tmo_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            val_op_q       <= val_op_d;
            commit_ack_q   <= commit_ack_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Buffer storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[word_cnt_q[ADDR_W-1:0]] <= dft_out;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_overflow   = err_overflow_q;
    assign err_timeout    = err_timeout_q;
    assign word_cnt       = word_cnt_q;
    assign rd_data        = rd_data_q;
    assign dft_val_op     = val_op_q;
    assign dft_commit_ack = commit_ack_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dft_dump_host.sv
// Bench for dft_dump_host: directed and randomized dumps scored against a
// queue model of which strobes land in the buffer.
module tb_dft_dump_host;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic              err_timeout;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              dft_val_op;
    logic              dft_op_ack;
    logic [31:0]       dft_out;
    logic              dft_out_strobe;
    logic              dft_op_commit;
    logic              dft_commit_ack;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    dft_dump_host #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_timeout(err_timeout), .word_cnt(word_cnt),
        .rd_addr(rd_addr), .rd_data(rd_data), .dft_val_op(dft_val_op),
        .dft_op_ack(dft_op_ack), .dft_out(dft_out), .dft_out_strobe(dft_out_strobe),
        .dft_op_commit(dft_op_commit), .dft_commit_ack(dft_commit_ack),
        .dbg_state(dbg_state)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          budget;
    logic [31:0] exp_q[$];
    logic [31:0] drive_q[$];
    logic        exp_ovf;

    always @(posedge clk) begin
        #2;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] next_word();
        if (drive_q.size() > 0) return drive_q.pop_front();
        return $urandom;
    endfunction

    // Strobe in the capture window (REQ..commit edge): stored while room remains.
    task automatic cap_strobe(input bit en);
        logic [31:0] d;
        if (en && budget > 0) begin
            d = next_word();
            dft_out_strobe = 1'b1;
            dft_out = d;
            budget--;
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
    endtask

    // Strobe outside the window: must be ignored.
    task automatic junk_strobe();
        dft_out_strobe = 1'b1;
        dft_out = $urandom;
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            rd_addr = ADDR_W'(i);
            cyc();
            check($sformatf("%s_rd%0d", tag, i), rd_data, exp_q[i]);
        end
    endtask

    task automatic run_dump(input int ack_delay, input int n_str, input bit str_on_ack,
                            input int hold, input bit start_in_ack, input string tag);
        int d0;
        int ack_hi;
        d0 = done_cnt;
        budget = n_str;
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        check({tag, "_busy_req"}, busy, 1);
        check({tag, "_valop_req"}, dft_val_op, 1);
        check({tag, "_cnt_clr"}, word_cnt, 0);
        check({tag, "_ovf_clr"}, err_overflow, 0);
        check({tag, "_tmo_clr"}, err_timeout, 0);
        for (int i = 0; i < ack_delay; i++) begin
            cap_strobe($urandom_range(0, 1) == 1);
            cyc();
            dft_out_strobe = 1'b0;
            check({tag, "_valop_hold"}, dft_val_op, 1);
        end
        dft_op_ack = 1'b1;
        cap_strobe(str_on_ack || ($urandom_range(0, 1) == 1));
        cyc();
        dft_op_ack = 1'b0;
        dft_out_strobe = 1'b0;
        check({tag, "_valop_drop"}, dft_val_op, 0);
        check({tag, "_busy_cap"}, busy, 1);
        while (budget > 1) begin
            cap_strobe(1'b1);
            cyc();
            dft_out_strobe = 1'b0;
        end
        dft_op_commit = 1'b1;
        cap_strobe(1'b1);
        cyc();
        dft_out_strobe = 1'b0;
        ack_hi = (dft_commit_ack === 1'b1) ? 1 : 0;
        for (int i = 1; i < hold; i++) begin
            junk_strobe();
            cyc();
            dft_out_strobe = 1'b0;
            if (dft_commit_ack === 1'b1) ack_hi++;
        end
        check({tag, "_ack_len"}, ack_hi, hold);
        dft_op_commit = 1'b0;
        junk_strobe();
        if (start_in_ack) start = 1'b1;
        cyc();
        start = 1'b0;
        check({tag, "_ack_drop"}, dft_commit_ack, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_done_hi"}, done, 1);
        junk_strobe();
        cyc();
        dft_out_strobe = 1'b0;
        check({tag, "_done_lo"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        cyc();
        check({tag, "_idle2"}, busy, 0);
        check({tag, "_cnt"}, word_cnt, exp_q.size());
        check({tag, "_ovf"}, err_overflow, exp_ovf);
        check({tag, "_tmo"}, err_timeout, 0);
        check({tag, "_done_n"}, done_cnt - d0, 1);
        readback(tag);
    endtask

    initial begin
        int hi;
        int d0;
        reset = 1'b0;
        start = 1'b0;
        rd_addr = '0;
        dft_op_ack = 1'b0;
        dft_out = '0;
        dft_out_strobe = 1'b0;
        dft_op_commit = 1'b0;
        repeat (3) cyc();
        check("rst_busy", busy, 0);
        check("rst_valop", dft_val_op, 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_rd", rd_data, 0);
        reset = 1'b1;
        repeat (2) cyc();
        check("idle_busy", busy, 0);

        drive_q = '{32'hDEADBEEF};
        run_dump(2, 1, 1'b0, 1, 1'b0, "single");

        drive_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_dump(1, 4, 1'b1, 1, 1'b0, "full");

        run_dump(1, 6, 1'b0, 2, 1'b0, "ovf");
        run_dump(0, 2, 1'b0, 5, 1'b1, "hold");

        // Timeout with ack withheld.
        d0 = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        hi = 0;
        for (int i = 0; i < 24; i++) begin
            if (dft_val_op === 1'b1) hi++;
            cyc();
        end
        check("tmo_req_len", hi, TMO);
        check("tmo_flag", err_timeout, 1);
        check("tmo_busy", busy, 0);
        check("tmo_nodone", done_cnt - d0, 0);

        for (int t = 0; t < 20; t++) begin
            run_dump($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1) == 1,
                     $urandom_range(1, 4), $urandom_range(0, 1) == 1, $sformatf("rnd%0d", t));
        end

        // Reset in the middle of CAPTURE.
        start = 1'b1;
        cyc();
        start = 1'b0;
        dft_op_ack = 1'b1;
        cyc();
        dft_op_ack = 1'b0;
        dft_out_strobe = 1'b1;
        dft_out = $urandom;
        cyc();
        dft_out_strobe = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_valop", dft_val_op, 0);
        check("mrst_cack", dft_commit_ack, 0);
        check("mrst_ovf", err_overflow, 0);
        check("mrst_tmo", err_timeout, 0);
        check("mrst_cnt", word_cnt, 0);
        check("mrst_rd", rd_data, 0);
        dft_op_commit = 1'b1;
        cyc();
        check("mrst_nocack", dft_commit_ack, 0);
        dft_op_commit = 1'b0;
        reset = 1'b1;
        repeat (3) cyc();
        check("mrst_after_busy", busy, 0);
        check("mrst_after_cack", dft_commit_ack, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
